// File: rtl/bridge_arbiter.sv
// Round-robin arbiter sharing one DRAM bridge command port among NUM_REQ requesters.
// One command in flight; a watchdog answers with an error and then drains the late completion.
module bridge_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_r_wb,
  input  logic [NUM_REQ*8-1:0]  req_addr,
  input  logic [NUM_REQ*64-1:0] req_data_w,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [63:0]           resp_data_r,
  output logic                  resp_err,
  output logic                  C_in_valid,
  output logic                  C_r_wb,
  output logic [7:0]            C_addr,
  output logic [63:0]           C_data_w,
  input  logic                  C_out_valid,
  input  logic [63:0]           C_data_r
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [PW-1:0] ptr_r, grant_r, gsel_s;
  logic          found_s, timeout_s;
  logic          r_wb_r, err_r;
  logic [7:0]    addr_r;
  logic [63:0]   data_w_r, rdata_r;
  logic [TW-1:0] timer_r;

  // (base + step) mod NUM_REQ; both operands are below NUM_REQ so one subtraction suffices
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input logic [PW:0] step);
    logic [PW+1:0] sum_v;
    sum_v = {2'b00, base} + {1'b0, step};
    if (sum_v >= (PW+2)'(NUM_REQ)) begin
      sum_v = sum_v - (PW+2)'(NUM_REQ);
    end else begin
      sum_v = sum_v;
    end
    return sum_v[PW-1:0];
  endfunction

  assign timeout_s = (timer_r == TW'(TIMEOUT - 1));

  // Round-robin search: scanning from the far end lets the candidate closest to ptr win
  always_comb begin
    found_s = 1'b0;
    gsel_s  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(ptr_r, (PW+1)'(k))]) begin
        found_s = 1'b1;
        gsel_s  = wrap_idx(ptr_r, (PW+1)'(k));
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and output decode; everything is held at zero while rst is high
  always_comb begin
    state_nxt_s = ST_IDLE;
    req_ready   = '0;
    resp_valid  = '0;
    resp_data_r = 64'd0;
    resp_err    = 1'b0;
    C_in_valid  = 1'b0;
    C_r_wb      = 1'b0;
    C_addr      = 8'd0;
    C_data_w    = 64'd0;
    if (rst) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            req_ready[gsel_s] = 1'b1;
            state_nxt_s       = ST_ISSUE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          C_in_valid  = 1'b1;
          C_r_wb      = r_wb_r;
          C_addr      = addr_r;
          C_data_w    = data_w_r;
          state_nxt_s = ST_WAIT;
        end
        ST_WAIT: begin
          if (C_out_valid || timeout_s) begin
            state_nxt_s = ST_RESP;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_RESP: begin
          resp_valid[grant_r] = 1'b1;
          resp_data_r         = rdata_r;
          resp_err            = err_r;
          state_nxt_s         = err_r ? ST_FLUSH : ST_IDLE;
        end
        ST_FLUSH: begin
          state_nxt_s = C_out_valid ? ST_IDLE : ST_FLUSH;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, request latches, watchdog timer and captured response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      ptr_r    <= '0;
      grant_r  <= '0;
      r_wb_r   <= 1'b0;
      addr_r   <= 8'd0;
      data_w_r <= 64'd0;
      timer_r  <= '0;
      rdata_r  <= 64'd0;
      err_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            grant_r  <= gsel_s;
            r_wb_r   <= req_r_wb[gsel_s];
            addr_r   <= req_addr[gsel_s*8 +: 8];
            data_w_r <= req_data_w[gsel_s*64 +: 64];
          end
        end
        ST_ISSUE: begin
          timer_r <= '0;
        end
        ST_WAIT: begin
          timer_r <= timer_r + TW'(1);
          // A completion on the timeout cycle still counts as success
          if (C_out_valid) begin
            rdata_r <= r_wb_r ? C_data_r : 64'd0;
            err_r   <= 1'b0;
          end else if (timeout_s) begin
            rdata_r <= 64'd0;
            err_r   <= 1'b1;
          end
        end
        ST_RESP: begin
          ptr_r <= wrap_idx(grant_r, (PW+1)'(1));
        end
        default: begin
          timer_r <= timer_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bridge_arbiter.sv
// Self-checking bench for bridge_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-timeline reference model.
module tb_bridge_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_r_wb = '0;
  logic [N*8-1:0]  req_addr = '0;
  logic [N*64-1:0] req_data_w = '0;
  logic [N-1:0]    req_ready, resp_valid;
  logic [63:0]     resp_data_r;
  logic            resp_err;
  logic            C_in_valid, C_r_wb;
  logic [7:0]      C_addr;
  logic [63:0]     C_data_w;
  logic            C_out_valid = 1'b0;
  logic [63:0]     C_data_r = 64'd0;

  always #5 clk = ~clk;

  bridge_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_r_wb(req_r_wb), .req_addr(req_addr), .req_data_w(req_data_w),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data_r(resp_data_r), .resp_err(resp_err),
    .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr), .C_data_w(C_data_w),
    .C_out_valid(C_out_valid), .C_data_r(C_data_r)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // pending requests per port
  bit          pv[N];
  bit          pr[N];
  logic [7:0]  pa[N];
  logic [63:0] pd[N];

  // reference model: one transaction timeline
  bit          busy = 1'b0;
  int          acc, ans_c, resp_c, free_c, mg;
  int          m_ptr = 0;
  bit          m_err;
  logic [63:0] m_rdata;
  bit          t_rwb;
  logic [7:0]  t_addr;
  logic [63:0] t_data;
  int          grants[$];

  int          force_lat = 0;
  bit          rand_en = 1'b0, hold_all = 1'b0, rst_req = 1'b0, fix_rd = 1'b0;
  logic [63:0] fix_rdata = 64'd0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (pv[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int rand_lat();
    int u;
    u = $urandom_range(0, 9);
    if (u < 7) return $urandom_range(1, 6);
    if (u == 7) return TO;
    if (u == 8) return TO - 1;
    return $urandom_range(TO + 2, TO + 6);
  endfunction

  task automatic set_req(input int p, input bit rwb, input logic [7:0] a, input logic [63:0] d);
    pv[p] = 1'b1; pr[p] = rwb; pa[p] = a; pd[p] = d;
  endtask

  task automatic new_req(input int p);
    set_req(p, 1'($urandom_range(0, 1)), 8'($urandom), {$urandom, $urandom});
  endtask

  task automatic clear_reqs();
    for (int p = 0; p < N; p++) pv[p] = 1'b0;
  endtask

  // one clock cycle: drive inputs, predict outputs, check, advance the model
  task automatic step();
    int g, lat;
    bit r;
    logic [N-1:0] e_ready, e_resp;
    bit e_civ, e_crwb, e_err;
    logic [7:0] e_caddr;
    logic [63:0] e_cdata, e_rdata;
    @(negedge clk);
    r = rst_req || (rand_en && ($urandom_range(0, 599) == 0));
    if (rand_en) begin
      for (int p = 0; p < N; p++) begin
        if (!pv[p] && $urandom_range(0, 3) == 0) new_req(p);
        else if (pv[p] && $urandom_range(0, 31) == 0) pv[p] = 1'b0;
      end
    end
    rst = r;
    for (int p = 0; p < N; p++) begin
      req_valid[p] = pv[p];
      req_r_wb[p] = pr[p];
      req_addr[8*p +: 8] = pa[p];
      req_data_w[64*p +: 64] = pd[p];
    end
    C_data_r = fix_rd ? fix_rdata : {$urandom, $urandom};
    C_out_valid = (busy && cyc == ans_c) || (!busy && rand_en && $urandom_range(0, 7) == 0);
    if (busy && cyc == ans_c && !m_err && t_rwb) m_rdata = C_data_r;
    e_ready = '0; e_resp = '0; e_civ = 1'b0; e_crwb = 1'b0; e_err = 1'b0;
    e_caddr = 8'd0; e_cdata = 64'd0; e_rdata = 64'd0; g = -1;
    if (!r) begin
      if (!busy) begin
        g = pick();
        if (g >= 0) e_ready[g] = 1'b1;
      end else begin
        if (cyc == acc + 1) begin
          e_civ = 1'b1; e_crwb = t_rwb; e_caddr = t_addr; e_cdata = t_data;
        end
        if (cyc == resp_c) begin
          e_resp[mg] = 1'b1; e_rdata = m_rdata; e_err = m_err;
        end
      end
    end
    #1;
    check_eq("req_ready", 64'(req_ready), 64'(e_ready));
    check_eq("C_in_valid", 64'(C_in_valid), 64'(e_civ));
    check_eq("C_r_wb", 64'(C_r_wb), 64'(e_crwb));
    check_eq("C_addr", 64'(C_addr), 64'(e_caddr));
    check_eq("C_data_w", C_data_w, e_cdata);
    check_eq("resp_valid", 64'(resp_valid), 64'(e_resp));
    check_eq("resp_data_r", resp_data_r, e_rdata);
    check_eq("resp_err", 64'(resp_err), 64'(e_err));
    if (r) begin
      busy = 1'b0;
      m_ptr = 0;
    end else if (g >= 0) begin
      busy = 1'b1; acc = cyc; mg = g;
      t_rwb = pr[g]; t_addr = pa[g]; t_data = pd[g];
      grants.push_back(g);
      m_ptr = (g + 1) % N;
      m_rdata = 64'd0;
      lat = (force_lat > 0) ? force_lat : rand_lat();
      ans_c = cyc + 1 + lat;
      if (lat <= TO) begin
        resp_c = cyc + 2 + lat; free_c = cyc + 3 + lat; m_err = 1'b0;
      end else begin
        resp_c = cyc + 2 + TO; free_c = ans_c + 1; m_err = 1'b1;
      end
      pv[g] = 1'b0;
      if (hold_all) new_req(g);
    end else if (busy && cyc + 1 == free_c) begin
      busy = 1'b0;
    end
    cyc++;
  endtask

  initial begin
    clear_reqs();
    rst_req = 1'b1;
    repeat (3) step();
    rst_req = 1'b0;
    step();

    // read on port 0, bridge answers after 6 cycles with a fixed pattern
    fix_rd = 1'b1; fix_rdata = 64'hDEAD_BEEF_0123_4567; force_lat = 6;
    set_req(0, 1'b1, 8'h05, 64'd0);
    repeat (12) step();
    fix_rd = 1'b0;

    // all ports continuously requesting from ptr=0
    rst_req = 1'b1; step(); rst_req = 1'b0;
    grants.delete(); hold_all = 1'b1; force_lat = 3;
    for (int p = 0; p < N; p++) new_req(p);
    repeat (32) step();
    hold_all = 1'b0;
    for (int i = 0; i < 5; i++)
      check_eq("rr_order", 64'((i < grants.size()) ? grants[i] : 99), 64'(i % N));
    clear_reqs();
    repeat (10) step();

    // write on port 2
    force_lat = 2;
    set_req(2, 1'b0, 8'hFF, 64'h1122_3344_5566_7788);
    repeat (8) step();

    // silent bridge: error response, then port 1 waits for the late completion
    grants.delete(); force_lat = TO + 4;
    set_req(0, 1'b1, 8'h33, 64'd0);
    step();
    force_lat = 3;
    set_req(1, 1'b1, 8'h44, 64'd0);
    repeat (32) step();
    check_eq("flush_grant0", 64'((grants.size() > 0) ? grants[0] : 99), 64'd0);
    check_eq("flush_grant1", 64'((grants.size() > 1) ? grants[1] : 99), 64'd1);

    // completion exactly on the timeout cycle
    force_lat = TO;
    set_req(3, 1'b1, 8'h5A, 64'd0);
    repeat (TO + 6) step();

    // reset during WAIT with port 3 granted; search restarts at port 0
    force_lat = 3;
    set_req(2, 1'b0, 8'h01, 64'hA5A5_0000_FFFF_1234);
    repeat (8) step();
    force_lat = 10;
    set_req(3, 1'b1, 8'h02, 64'd0);
    repeat (5) step();
    set_req(1, 1'b1, 8'h03, 64'd0);
    set_req(3, 1'b1, 8'h04, 64'd0);
    rst_req = 1'b1; step(); rst_req = 1'b0;
    grants.delete(); force_lat = 3;
    repeat (10) step();
    check_eq("rst_grant", 64'((grants.size() > 0) ? grants[0] : 99), 64'd1);
    repeat (10) step();

    // randomized traffic
    force_lat = 0; rand_en = 1'b1;
    repeat (3000) step();
    rand_en = 1'b0;
    clear_reqs();
    repeat (40) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
